// File: rtl/raster_pkg.sv
// raster_pkg: shared types, widths and edge-function helpers for the triangle scan sequencer.
package raster_pkg;
  localparam int COORD_W = 16;
  localparam int ACC_W = 2 * COORD_W + 2;
  typedef enum logic [2:0] {IDLE, SETUP_A, SETUP_B, SCAN, DONE} state_t;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W:0] delta_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = a < b ? a : b;
    return m < c ? m : c;
  endfunction
  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
  function automatic acc_t edge_fn(input delta_t a, input delta_t b, input coord_t x, input coord_t y,
                                   input coord_t xr, input coord_t yr);
    return acc_t'(a) * acc_t'(delta_t'(x) - delta_t'(xr)) + acc_t'(b) * acc_t'(delta_t'(y) - delta_t'(yr));
  endfunction
  // Inclusive rule: zero on an edge counts as inside, sign must match detT.
  function automatic logic is_inside(input acc_t e0, input acc_t e1, input acc_t e2, input acc_t det);
    return det > 0 ? (e0 >= 0 && e1 >= 0 && e2 >= 0) : (det < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction
endpackage

// File: rtl/raster_edge_setup.sv
// raster_edge_setup: combinational bbox clip, edge deltas, detT and initial edge values.
module raster_edge_setup
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  coord_t x1,
  input  coord_t y1,
  input  coord_t x2,
  input  coord_t y2,
  input  coord_t x3,
  input  coord_t y3,
  input  delta_t a0,
  input  delta_t b0,
  input  delta_t a1,
  input  delta_t b1,
  input  coord_t xmin,
  input  coord_t ymin,
  output coord_t bx_min,
  output coord_t bx_max,
  output coord_t by_min,
  output coord_t by_max,
  output delta_t a0_n,
  output delta_t b0_n,
  output delta_t a1_n,
  output delta_t b1_n,
  output acc_t   det,
  output acc_t   e0,
  output acc_t   e1
);
  coord_t lo_x, hi_x, lo_y, hi_y;
  assign lo_x = min3(x1, x2, x3);
  assign hi_x = max3(x1, x2, x3);
  assign lo_y = min3(y1, y2, y3);
  assign hi_y = max3(y1, y2, y3);
  assign bx_min = lo_x < 0 ? '0 : lo_x;
  assign by_min = lo_y < 0 ? '0 : lo_y;
  assign bx_max = hi_x > coord_t'(SCREEN_W - 1) ? coord_t'(SCREEN_W - 1) : hi_x;
  assign by_max = hi_y > coord_t'(SCREEN_H - 1) ? coord_t'(SCREEN_H - 1) : hi_y;
  assign a0_n = delta_t'(y2) - delta_t'(y3);
  assign b0_n = delta_t'(x3) - delta_t'(x2);
  assign a1_n = delta_t'(y3) - delta_t'(y1);
  assign b1_n = delta_t'(x1) - delta_t'(x3);
  assign det = edge_fn(a0, b0, x1, y1, x3, y3);
  assign e0 = edge_fn(a0, b0, xmin, ymin, x3, y3);
  assign e1 = edge_fn(a1, b1, xmin, ymin, x3, y3);
endmodule

// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: walks a triangle's clipped bbox one pixel per cycle and streams inside pixels.
module raster_scan_ctrl
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        abort,
  input  coord_t      x1,
  input  coord_t      y1,
  input  coord_t      x2,
  input  coord_t      y2,
  input  coord_t      x3,
  input  coord_t      y3,
  output logic        busy,
  output logic        done,
  output logic        px_valid,
  input  logic        px_ready,
  output coord_t      px_x,
  output coord_t      px_y,
  output logic [31:0] pixel_count
);
  state_t state;
  coord_t vx1, vy1, vx2, vy2, vx3, vy3, xmin, xmax, ymin, ymax, cx, cy;
  coord_t s_xmin, s_xmax, s_ymin, s_ymax;
  delta_t a0, b0, a1, b1, s_a0, s_b0, s_a1, s_b1;
  acc_t det, e0, e1, r0, r1, s_det, s_e0, s_e1, e2;
  logic fin, inside_px, slot_free, hs, adv, last, row_end;
  raster_edge_setup #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_setup (
    .x1(vx1), .y1(vy1), .x2(vx2), .y2(vy2), .x3(vx3), .y3(vy3),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .xmin(xmin), .ymin(ymin),
    .bx_min(s_xmin), .bx_max(s_xmax), .by_min(s_ymin), .by_max(s_ymax),
    .a0_n(s_a0), .b0_n(s_b0), .a1_n(s_a1), .b1_n(s_b1),
    .det(s_det), .e0(s_e0), .e1(s_e1)
  );
  assign e2 = det - e0 - e1;
  assign inside_px = is_inside(e0, e1, e2, det);
  assign slot_free = !px_valid || px_ready;
  assign hs = px_valid && px_ready;
  assign adv = !inside_px || slot_free;
  assign row_end = cx == xmax;
  assign last = row_end && cy == ymax;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      px_valid <= 1'b0;
      px_x <= '0;
      px_y <= '0;
      pixel_count <= '0;
      fin <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      px_valid <= 1'b0;
      fin <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hs) begin
        px_valid <= 1'b0;
        pixel_count <= pixel_count + 32'd1;
      end
      case (state)
        IDLE: if (start) begin
          {vx1, vy1, vx2, vy2, vx3, vy3} <= {x1, y1, x2, y2, x3, y3};
          pixel_count <= '0;
          busy <= 1'b1;
          state <= SETUP_A;
        end
        SETUP_A: begin
          {xmin, xmax, ymin, ymax} <= {s_xmin, s_xmax, s_ymin, s_ymax};
          {a0, b0, a1, b1} <= {s_a0, s_b0, s_a1, s_b1};
          state <= SETUP_B;
        end
        SETUP_B: begin
          det <= s_det;
          {e0, r0, e1, r1} <= {s_e0, s_e0, s_e1, s_e1};
          cx <= xmin;
          cy <= ymin;
          fin <= 1'b0;
          if (s_det == 0 || xmin > xmax || ymin > ymax) begin
            state <= DONE;
            done <= 1'b1;
          end else state <= SCAN;
        end
        SCAN: if (fin) begin
          if (slot_free) begin
            state <= DONE;
            done <= 1'b1;
          end
        end else if (adv) begin
          if (inside_px) begin
            px_valid <= 1'b1;
            px_x <= cx;
            px_y <= cy;
          end
          // The last pixel may still be waiting in the output slot, so drain before finishing.
          if (last) begin
            if (inside_px || !slot_free) fin <= 1'b1;
            else begin
              state <= DONE;
              done <= 1'b1;
            end
          end else if (row_end) begin
            r0 <= r0 + acc_t'(b0);
            r1 <= r1 + acc_t'(b1);
            e0 <= r0 + acc_t'(b0);
            e1 <= r1 + acc_t'(b1);
            cx <= xmin;
            cy <= cy + coord_t'(1);
          end else begin
            e0 <= e0 + acc_t'(a0);
            e1 <= e1 + acc_t'(a1);
            cx <= cx + coord_t'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// tb_raster_scan_ctrl: scoreboard bench on a 16x16 screen against an independent orientation model.
module tb_raster_scan_ctrl;
  logic HCLK = 1'b0;
  logic HRESET, start, abort, px_ready;
  logic signed [15:0] x1, y1, x2, y2, x3, y3;
  logic busy, done, px_valid;
  logic signed [15:0] px_x, px_y;
  logic [31:0] pixel_count;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {int x; int y;} pix_t;
  pix_t exp_q[$];
  logic stall_prev = 1'b0;
  logic signed [15:0] prev_x, prev_y;

  raster_scan_ctrl #(.SCREEN_W(16), .SCREEN_H(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .busy(busy), .done(done), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .pixel_count(pixel_count)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    pix_t e;
    if (HRESET || abort) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        vectors++;
        if (px_valid !== 1'b1 || px_x !== prev_x || px_y !== prev_y) begin
          miscompares++;
          $display("FAIL hold: got v=%0b (%0d,%0d) expected v=1 (%0d,%0d)", px_valid, px_x, px_y, prev_x, prev_y);
        end
      end
      if (px_valid && px_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_pixel: got (%0d,%0d) expected none", px_x, px_y);
        end else begin
          e = exp_q.pop_front();
          if (int'(px_x) != e.x || int'(px_y) != e.y) begin
            miscompares++;
            $display("FAIL pixel: got (%0d,%0d) expected (%0d,%0d)", px_x, px_y, e.x, e.y);
          end
        end
        vectors++;
        if (px_x < 0 || px_x > 15 || px_y < 0 || px_y > 15) begin
          miscompares++;
          $display("FAIL onscreen: got (%0d,%0d) expected within 0..15", px_x, px_y);
        end
      end
      stall_prev = px_valid && !px_ready;
      prev_x = px_x;
      prev_y = px_y;
    end
  end

  function automatic int load_expected(int ax, int ay, int bx, int by, int cx, int cy);
    int d, w0, w1, w2, n;
    pix_t p;
    n = 0;
    d = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        w0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
        w1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
        w2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
        if ((d > 0 && w0 >= 0 && w1 >= 0 && w2 >= 0) || (d < 0 && w0 <= 0 && w1 <= 0 && w2 <= 0)) begin
          p.x = x;
          p.y = y;
          exp_q.push_back(p);
          n++;
        end
      end
    return n;
  endfunction

  task automatic kick(int ax, int ay, int bx, int by, int cx, int cy);
    @(posedge HCLK); #1;
    start = 1'b1;
    x1 = 16'(ax); y1 = 16'(ay); x2 = 16'(bx); y2 = 16'(by); x3 = 16'(cx); y3 = 16'(cy);
    @(posedge HCLK); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(output int first, output int donec, output bit tmo);
    first = -1;
    donec = -1;
    tmo = 1'b1;
    for (int c = 2; c < 3000; c++) begin
      @(posedge HCLK); #1;
      if (px_valid && first < 0) first = c;
      if (done) begin
        donec = c;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b1;
    {x1, y1, x2, y2, x3, y3} = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    vectors++;
    if ({busy, done, px_valid} !== 3'b000 || px_x !== 16'sd0 || px_y !== 16'sd0 || pixel_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: got b=%0b d=%0b v=%0b x=%0d y=%0d n=%0d expected all 0", busy, done, px_valid, px_x, px_y, pixel_count);
    end
  endtask

  task automatic test_basic();
    int n, first, donec;
    bit tmo;
    n = load_expected(0, 0, 4, 0, 0, 4);
    kick(0, 0, 4, 0, 0, 4);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %0b expected 1", busy); end
    run_to_done(first, donec, tmo);
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL basic_timeout: got no done expected done"); end
    vectors++;
    if (first != 4) begin miscompares++; $display("FAIL basic_first_valid: got cycle %0d expected 4", first); end
    vectors++;
    if (donec != 28) begin miscompares++; $display("FAIL basic_done_cycle: got %0d expected 28", donec); end
    vectors++;
    if (pixel_count !== 32'(n) || n != 15) begin miscompares++; $display("FAIL basic_count: got %0d expected 15", pixel_count); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_missing: got %0d left expected 0", exp_q.size()); end
    @(posedge HCLK); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: got d=%0b b=%0b expected 0 0", done, busy); end
  endtask

  task automatic test_clockwise();
    int n, first, donec;
    bit tmo;
    n = load_expected(0, 0, 0, 4, 4, 0);
    kick(0, 0, 0, 4, 4, 0);
    run_to_done(first, donec, tmo);
    vectors++;
    if (tmo || pixel_count !== 32'd15 || n != 15) begin
      miscompares++;
      $display("FAIL cw_count: got %0d (tmo=%0b) expected 15", pixel_count, tmo);
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL cw_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_degenerate();
    int n, first, donec;
    bit tmo;
    n = load_expected(0, 0, 2, 2, 4, 4);
    kick(0, 0, 2, 2, 4, 4);
    run_to_done(first, donec, tmo);
    vectors++;
    if (donec != 3) begin miscompares++; $display("FAIL degen_done_cycle: got %0d expected 3", donec); end
    vectors++;
    if (first != -1) begin miscompares++; $display("FAIL degen_valid: got valid at %0d expected never", first); end
    vectors++;
    if (pixel_count !== 32'd0 || n != 0) begin miscompares++; $display("FAIL degen_count: got %0d expected 0", pixel_count); end
  endtask

  task automatic test_stall();
    int n, first, donec;
    bit tmo, seen;
    n = load_expected(0, 0, 4, 0, 0, 4);
    px_ready = 1'b0;
    kick(0, 0, 4, 0, 0, 4);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge HCLK); #1;
      seen = px_valid;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL stall_valid: got no px_valid expected px_valid"); end
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); #1;
      vectors++;
      if (px_valid !== 1'b1 || px_x !== 16'sd0 || px_y !== 16'sd0) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%0b (%0d,%0d) expected v=1 (0,0)", px_valid, px_x, px_y);
      end
    end
    px_ready = 1'b1;
    run_to_done(first, donec, tmo);
    vectors++;
    if (tmo || pixel_count !== 32'd15 || n != 15) begin
      miscompares++;
      $display("FAIL stall_count: got %0d (tmo=%0b) expected 15", pixel_count, tmo);
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_clip();
    int n, first, donec;
    bit tmo;
    n = load_expected(-5, -5, 20, -5, -5, 20);
    kick(-5, -5, 20, -5, -5, 20);
    run_to_done(first, donec, tmo);
    vectors++;
    if (tmo || pixel_count !== 32'd136 || n != 136) begin
      miscompares++;
      $display("FAIL clip_count: got %0d (tmo=%0b) expected 136", pixel_count, tmo);
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL clip_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_interrupt(bit use_reset);
    int n, first, donec;
    bit tmo, saw_done;
    logic [31:0] pc;
    n = load_expected(0, 0, 4, 0, 0, 4);
    kick(0, 0, 4, 0, 0, 4);
    repeat (9) @(posedge HCLK);
    #1;
    if (use_reset) HRESET = 1'b1;
    else abort = 1'b1;
    pc = use_reset ? 32'd0 : pixel_count;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    abort = 1'b0;
    exp_q.delete();
    vectors++;
    if (busy !== 1'b0 || px_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got b=%0b v=%0b d=%0b expected 0 0 0", use_reset ? "rst" : "abort", busy, px_valid, done);
    end
    vectors++;
    if (pixel_count !== pc) begin
      miscompares++;
      $display("FAIL %s_count: got %0d expected %0d", use_reset ? "rst" : "abort", pixel_count, pc);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge HCLK); #1;
      saw_done |= done | px_valid;
    end
    vectors++;
    if (saw_done) begin miscompares++; $display("FAIL %s_quiet: got done/valid expected none", use_reset ? "rst" : "abort"); end
    n = load_expected(0, 0, 4, 0, 0, 4);
    kick(0, 0, 4, 0, 0, 4);
    run_to_done(first, donec, tmo);
    vectors++;
    if (tmo || pixel_count !== 32'd15 || donec != 28 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_rerun: got n=%0d done@%0d left=%0d expected n=15 done@28 left=0", use_reset ? "rst" : "abort", pixel_count, donec, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clockwise();
    test_degenerate();
    test_stall();
    test_clip();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    repeat (2) @(posedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
